register_write_arbiter: RTL
===========================

REGISTER_WRITE_ARBITER -- requirements
Module: register_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: data width of the shared register.
REQ-002 Parameter REQUESTERS, default 4: number of write requesters; legal range 2..16.
REQ-003 clock  in  1  system clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req  in  REQUESTERS  per-requester write request; requester holds it high until its ack.
REQ-006 wdata  in  REQUESTERS x WIDTH  per-requester write data; stable while req high.
REQ-007 clr_req  in  1  clear request; held high until clr_ack.
REQ-008 load  out  1  drives the shared register's load input.
REQ-009 clear  out  1  drives the shared register's clear input.
REQ-010 d  out  WIDTH  drives the shared register's data input.
REQ-011 ack  out  REQUESTERS  one-hot, one-cycle pulse to the requester whose write committed.
REQ-012 clr_ack  out  1  one-cycle pulse when the clear committed.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 last_grant  out  clog2(REQUESTERS)  index of the most recently granted requester.

Function
REQ-015 FSM states: IDLE, CLEAR, LOAD, ACK; exactly one state active per cycle.
REQ-016 IDLE: clr_req high -> CLEAR; else any req high -> LOAD; else stay IDLE.
REQ-017 clr_req has priority over all req; pending req are kept and served after CLEAR.
REQ-018 CLEAR: clear=1 and clr_ack=1 for that one cycle; next state IDLE.
REQ-019 IDLE->LOAD transition latches winner index and wdata[winner] into d; d holds that value during LOAD.
REQ-020 LOAD: load=1 for that one cycle; next state ACK.
REQ-021 ACK: ack[winner]=1 for that one cycle; last_grant updated to winner; next state IDLE.
REQ-022 req is ignored in LOAD and ACK; clr_req is ignored in CLEAR, LOAD, ACK.
REQ-023 Round-robin: search starts at (last_grant+1) mod REQUESTERS and wraps; first req high wins.
REQ-024 Latency: req sampled high in IDLE at cycle t -> load=1 in t+1 -> ack in t+2 -> IDLE in t+3.
REQ-025 Throughput: at most one write per 3 cycles; clear costs 1 cycle plus return to IDLE.
REQ-026 Requester deasserts req in the cycle after its ack; a req still high in IDLE is a new request.
REQ-027 load and clear are never high in the same cycle; ack and clr_ack never high in the same cycle.
REQ-028 Outputs load, clear, ack, clr_ack are 0 in IDLE.

Reset
REQ-029 reset high at a rising edge forces IDLE, load=0, clear=0, ack=0, clr_ack=0, busy=0, d=0.
REQ-030 reset sets last_grant=REQUESTERS-1 so requester 0 has first priority.
REQ-031 reset mid-LOAD or mid-ACK abandons the transaction: no ack issued; requester keeps req high and is re-arbitrated.

Structure
REQ-032 Package register_arbiter_pkg holds the state enum and default WIDTH/REQUESTERS constants.
REQ-033 Sub-module round_robin_picker: combinational; inputs req vector and last_grant; outputs valid and winner index.

Verification (WIDTH=4, REQUESTERS=4)
REQ-034 Single req[2], wdata[2]=4'b1010 -> load in t+1 with d=1010, ack=0100 in t+2, register q=1010, last_grant=2.
REQ-035 req=1111 held with auto-deassert after ack, after reset -> grant order 0,1,2,3; ack sequence 0001,0010,0100,1000.
REQ-036 After last_grant=3, req=1001 -> requester 0 wins (wrap), then 3.
REQ-037 clr_req and req[1] high together in IDLE -> clear+clr_ack first, then LOAD for requester 1; q goes 0000 then wdata[1].
REQ-038 reset asserted during LOAD for requester 2 -> next cycle IDLE, no ack, d=0; req[2] then re-served with full 3-cycle latency.
REQ-039 Every cycle assert: load & clear never both 1; ack is zero or one-hot; busy equals (state != IDLE).

Source files
------------

// File: rtl/register_arbiter_pkg.sv
// register_arbiter_pkg: shared state encoding and default sizes for the register write arbiter
package register_arbiter_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_REQUESTERS = 4;
  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, ACK} state_t;
endpackage

// File: rtl/round_robin_picker.sv
// round_robin_picker: combinational round-robin search starting just after last_grant
module round_robin_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic                 valid,
  output logic [$clog2(N)-1:0] winner
);
  int k;
  // scan from farthest to nearest so the requester right after last_grant overwrites last
  always_comb begin
    valid = 1'b0;
    winner = '0;
    k = 0;
    for (int i = N; i >= 1; i--) begin
      k = (int'(last_grant) + i) % N;
      if (req[k]) begin
        valid = 1'b1;
        winner = ($clog2(N))'(k);
      end
    end
  end
endmodule

// File: rtl/register_write_arbiter.sv
// register_write_arbiter: serialises clear and round-robin write requests onto one shared register
module register_write_arbiter
  import register_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REQUESTERS = DEF_REQUESTERS
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [REQUESTERS-1:0]               req,
  input  logic [REQUESTERS-1:0][WIDTH-1:0]    wdata,
  input  logic                                clr_req,
  output logic                                load,
  output logic                                clear,
  output logic [WIDTH-1:0]                    d,
  output logic [REQUESTERS-1:0]               ack,
  output logic                                clr_ack,
  output logic                                busy,
  output logic [$clog2(REQUESTERS)-1:0]       last_grant
);
  localparam int IW = $clog2(REQUESTERS);
  state_t state, next_state;
  logic [IW-1:0] winner, pick;
  logic pick_valid;
  round_robin_picker #(.N(REQUESTERS)) u_picker (
    .req(req),
    .last_grant(last_grant),
    .valid(pick_valid),
    .winner(pick)
  );
  // clear wins over writes; LOAD and ACK run to completion regardless of inputs
  always_comb begin
    next_state = state == IDLE ? (clr_req ? CLEAR : pick_valid ? LOAD : IDLE) :
                 state == LOAD ? ACK : IDLE;
    load = state == LOAD;
    clear = state == CLEAR;
    clr_ack = state == CLEAR;
    busy = state != IDLE;
    ack = state == ACK ? {{(REQUESTERS-1){1'b0}}, 1'b1} << winner : '0;
  end
  // winner and its data are captured on grant; priority pointer advances when the write commits
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      winner <= '0;
      d <= '0;
      last_grant <= IW'(REQUESTERS - 1);
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == LOAD) begin
        winner <= pick;
        d <= wdata[pick];
      end
      if (state == LOAD) last_grant <= winner;
    end
  end
endmodule
